// File: rtl/result_mux_reg.sv
// result_mux_reg: registered channel-select mux with valid/ready handshake,
// CNVZ status register, sticky overflow/select-error bits and a saturating transfer count.
module result_mux_reg #(
    parameter int WIDTH = 8,
    parameter int NCH = 3,
    localparam int SELW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [SELW-1:0]      SEL,
    input  logic [NCH*WIDTH-1:0] DATA_IN,
    input  logic [NCH*4-1:0]     CNVZ_IN,
    input  logic                 FLAG_WE,
    input  logic                 CLR_STICKY,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [WIDTH-1:0]     DOUT,
    output logic                 C,
    output logic                 N,
    output logic                 V,
    output logic                 Z,
    output logic                 STICKY_V,
    output logic                 SEL_ERR,
    output logic [7:0]           XFER_CNT
);
    logic             accept, sel_oob;
    logic [WIDTH-1:0] data_sel, dout_d, dout_q;
    logic [3:0]       flag_sel, flags_d, flags_q;
    logic             valid_d, valid_q, sticky_d, sticky_q, err_d, err_q;
    logic [7:0]       cnt_d, cnt_q;

    assign IN_READY = !valid_q || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    assign sel_oob  = 32'(SEL) >= NCH;

    // Any SEL without a matching channel falls through to the last channel.
    always_comb begin
        data_sel = DATA_IN[(NCH-1)*WIDTH +: WIDTH];
        flag_sel = CNVZ_IN[(NCH-1)*4 +: 4];
        for (int k = 0; k < NCH - 1; k++) begin
            if (32'(SEL) == k) begin
                data_sel = DATA_IN[k*WIDTH +: WIDTH];
                flag_sel = CNVZ_IN[k*4 +: 4];
            end
        end
    end

    always_comb begin
        valid_d  = accept ? 1'b1 : (OUT_READY ? 1'b0 : valid_q);
        dout_d   = accept ? data_sel : dout_q;
        flags_d  = (accept && FLAG_WE) ? flag_sel : flags_q;
        sticky_d = CLR_STICKY ? 1'b0 : (sticky_q || (accept && FLAG_WE && flag_sel[2]));
        err_d    = CLR_STICKY ? 1'b0 : (err_q || (accept && sel_oob));
        cnt_d    = (accept && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q  <= 1'b0;
            dout_q   <= '0;
            flags_q  <= '0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            dout_q   <= dout_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign OUT_VALID    = valid_q;
    assign DOUT         = dout_q;
    assign {Z, V, N, C} = flags_q;
    assign STICKY_V     = sticky_q;
    assign SEL_ERR      = err_q;
    assign XFER_CNT     = cnt_q;
endmodule

// File: tb/tb_result_mux_reg.sv
// tb_result_mux_reg: directed and random checks of result_mux_reg against a transaction-level model.
module tb_result_mux_reg;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RST_N;

    logic        in_valid, in_ready, flag_we, clr_sticky, out_valid, out_ready;
    logic [1:0]  sel;
    logic [23:0] data_in;
    logic [11:0] cnvz_in;
    logic [7:0]  dout, xfer_cnt;
    logic        c, n, v, z, sticky_v, sel_err;

    logic        in_valid2, in_ready2, out_valid2, c2, n2, v2, z2, sticky2, sel_err2;
    logic [2:0]  sel2;
    logic [79:0] data_in2;
    logic [19:0] cnvz2;
    logic [15:0] dout2;
    logic [7:0]  cnt2;

    result_mux_reg u_dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(in_valid), .IN_READY(in_ready), .SEL(sel),
        .DATA_IN(data_in), .CNVZ_IN(cnvz_in), .FLAG_WE(flag_we), .CLR_STICKY(clr_sticky),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .DOUT(dout), .C(c), .N(n), .V(v), .Z(z),
        .STICKY_V(sticky_v), .SEL_ERR(sel_err), .XFER_CNT(xfer_cnt)
    );

    result_mux_reg #(.WIDTH(16), .NCH(5)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(in_valid2), .IN_READY(in_ready2), .SEL(sel2),
        .DATA_IN(data_in2), .CNVZ_IN(cnvz2), .FLAG_WE(1'b0), .CLR_STICKY(1'b0),
        .OUT_VALID(out_valid2), .OUT_READY(1'b1), .DOUT(dout2), .C(c2), .N(n2), .V(v2), .Z(z2),
        .STICKY_V(sticky2), .SEL_ERR(sel_err2), .XFER_CNT(cnt2)
    );

    int n_chk = 0, n_err = 0;
    int m_valid, m_dout, m_flags, m_sticky, m_err, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_dout = 0; m_flags = 0; m_sticky = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, "_dout"}, dout, m_dout);
        chk({ctx, "_out_valid"}, out_valid, m_valid);
        chk({ctx, "_zvnc"}, {z, v, n, c}, m_flags);
        chk({ctx, "_sticky_v"}, sticky_v, m_sticky);
        chk({ctx, "_sel_err"}, sel_err, m_err);
        chk({ctx, "_xfer_cnt"}, xfer_cnt, m_cnt);
    endtask

    // One clock of stimulus; the model works on whole transactions, not on RTL state.
    task automatic step(input logic vi, input logic [1:0] s, input logic [23:0] d,
                        input logic [11:0] f, input logic fwe, input logic clr, input logic ordy);
        int rdy, acc, ch;
        @(negedge CLK);
        in_valid = vi; sel = s; data_in = d; cnvz_in = f;
        flag_we = fwe; clr_sticky = clr; out_ready = ordy;
        #1;
        rdy = (m_valid == 0 || ordy) ? 1 : 0;
        chk("in_ready", in_ready, rdy);
        acc = (vi && rdy) ? 1 : 0;
        ch = (s >= 3) ? 2 : int'(s);
        if (acc != 0) begin
            m_dout = int'((d >> (8 * ch)) & 24'hFF);
            if (fwe) begin
                m_flags = int'((f >> (4 * ch)) & 12'hF);
                if (m_flags[2]) m_sticky = 1;
            end
            if (s >= 3) m_err = 1;
            if (m_cnt < 255) m_cnt++;
            m_valid = 1;
        end else if (ordy) begin
            m_valid = 0;
        end
        if (clr) begin
            m_sticky = 0;
            m_err = 0;
        end
        @(posedge CLK);
        #1;
        check_all("step");
    endtask

    initial begin
        RST_N = 1'b0;
        in_valid = 0; sel = 0; data_in = 0; cnvz_in = 0; flag_we = 0; clr_sticky = 0; out_ready = 0;
        in_valid2 = 0; sel2 = 0; data_in2 = 0; cnvz2 = 0;
        model_reset();
        #2;
        check_all("reset");
        chk("reset_in_ready", in_ready, 1);
        @(negedge CLK);
        RST_N = 1'b1;

        // Wide instance: channel 4, then out-of-range select mapped onto channel 4.
        @(negedge CLK);
        in_valid2 = 1; sel2 = 3'd4; data_in2 = {16'hBEEF, 64'h4444_3333_2222_1111};
        @(posedge CLK); #1;
        chk("w16_dout", dout2, 16'hBEEF);
        chk("w16_valid", out_valid2, 1);
        chk("w16_err0", sel_err2, 0);
        @(negedge CLK);
        sel2 = 3'd7; data_in2 = {16'h1234, 64'h4444_3333_2222_1111};
        @(posedge CLK); #1;
        chk("w16_oob_dout", dout2, 16'h1234);
        chk("w16_oob_err", sel_err2, 1);
        @(negedge CLK);
        in_valid2 = 0;

        step(1, 2'd1, 24'h332211, 12'h000, 0, 0, 1);
        chk("basic_dout", dout, 8'h22);
        chk("basic_cnt", xfer_cnt, 1);

        step(0, 2'd0, 24'h0, 12'h0, 0, 0, 1);
        step(1, 2'd0, 24'h0000AA, 12'h0, 0, 0, 0);
        step(1, 2'd0, 24'h0000BB, 12'h0, 0, 0, 0);
        step(1, 2'd0, 24'h0000CC, 12'h0, 0, 0, 0);
        chk("stall_dout", dout, 8'hAA);
        chk("stall_cnt", xfer_cnt, 2);

        step(0, 2'd0, 24'h0, 12'h0, 0, 0, 1);
        step(1, 2'd3, 24'hA50000, 12'h0, 0, 0, 1);
        chk("oob_dout", dout, 8'hA5);
        chk("oob_err", sel_err, 1);
        step(0, 2'd0, 24'h0, 12'h0, 0, 1, 1);
        chk("oob_clr", sel_err, 0);

        step(1, 2'd0, 24'h000011, 12'h004, 1, 0, 1);
        step(1, 2'd0, 24'h000012, 12'h009, 0, 0, 1);
        chk("flags_held", {z, v, n, c}, 4'b0100);
        chk("flags_sticky", sticky_v, 1);

        step(1, 2'd3, 24'h7F0000, 12'h400, 1, 1, 1);
        chk("clr_prio_sticky", sticky_v, 0);
        chk("clr_prio_err", sel_err, 0);

        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 24'($urandom), 12'($urandom),
                 1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));

        for (int i = 0; i < 300; i++)
            step(1, 2'($urandom_range(0, 2)), 24'($urandom), 12'h0, 0, 0, 1);
        chk("sat_cnt", xfer_cnt, 255);

        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_in_ready", in_ready, 1);
        @(posedge CLK); #1;
        check_all("rst_hold");
        @(negedge CLK);
        in_valid = 0;
        RST_N = 1'b1;
        step(1, 2'd2, 24'h5A0000, 12'h0, 0, 0, 1);
        chk("post_rst_cnt", xfer_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
